// File: rtl/ldpc_pkg.sv
// Shared LDPC definitions: default code dimensions, the generator parity
// matrix, the encoder state type and a helper that extracts one row of the
// flat parity matrix.
package ldpc_pkg;

   localparam int unsigned LDPC_N = 6;
   localparam int unsigned LDPC_K = 3;
   localparam int unsigned LDPC_M = LDPC_N - LDPC_K;

   // P[i][j] = LDPC_P_MATRIX[i*(N-K)+j]
   localparam logic [LDPC_K*LDPC_M-1:0] LDPC_P_MATRIX = 9'h173;

   // Fixed container widths so par_row can serve any code size up to these.
   localparam int unsigned PAR_ROW_W = 32;
   localparam int unsigned P_FLAT_W  = 1024;

   typedef enum logic {
      S_MSG = 1'b0,
      S_PAR = 1'b1
   } state_e;

   // Row i of a flat parity matrix with m columns, LSB = column 0.
   function automatic logic [PAR_ROW_W-1:0] par_row(
      input logic [P_FLAT_W-1:0] p,
      input int unsigned         i,
      input int unsigned         m
   );
      logic [PAR_ROW_W-1:0] row;
      row = '0;
      for (int unsigned j = 0; j < PAR_ROW_W; j++) begin
         if ((j < m) && ((i * m + j) < P_FLAT_W)) begin
            row[j] = p[i * m + j];
         end
      end
      return row;
   endfunction

endpackage

// File: rtl/ldpc_encoder_if.sv
// Bit-serial stream bundle between a source/sink and the LDPC encoder.
//   in_valid/in_ready/in_bit            message bit stream into the encoder
//   out_valid/out_ready/out_bit         codeword bit stream out of the encoder
//   out_sop/out_eop                     first/last codeword bit markers
//   cw_count                            codewords fully accepted downstream
// master: the environment driving the encoder; slave: the encoder itself.
interface ldpc_encoder_if #(
   parameter int unsigned WIDTH = 20
);
   logic             in_valid;
   logic             in_ready;
   logic             in_bit;
   logic             out_valid;
   logic             out_ready;
   logic             out_bit;
   logic             out_sop;
   logic             out_eop;
   logic [WIDTH-1:0] cw_count;

   modport master (
      output in_valid, in_bit, out_ready,
      input  in_ready, out_valid, out_bit, out_sop, out_eop, cw_count
   );

   modport slave (
      input  in_valid, in_bit, out_ready,
      output in_ready, out_valid, out_bit, out_sop, out_eop, cw_count
   );
endinterface

// File: rtl/ldpc_encoder.sv
// Bit-serial systematic LDPC encoder. Takes K message bits, forwards them
// unchanged, then emits N-K parity bits p_j = XOR_i m_i & P[i][j].
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active low
//   bus   ldpc_encoder_if slave: input stream, output stream with sop/eop,
//         and the count of codewords accepted downstream
//
// state | meaning
// ------+-----------------------------------------------------------------
// S_MSG | accepting message bits, each forwarded and folded into parity
// S_PAR | input stalled, parity bits shifted out one per free output slot
module ldpc_encoder
   import ldpc_pkg::*;
#(
   parameter int unsigned         N        = LDPC_N,
   parameter int unsigned         K        = LDPC_K,
   parameter int unsigned         WIDTH    = 20,
   parameter logic [K*(N-K)-1:0]  P_MATRIX = LDPC_P_MATRIX
) (
   input  logic           clk,
   input  logic           rst,
   ldpc_encoder_if.slave  bus
);

   localparam int unsigned M       = N - K;
   localparam int unsigned IDX_MAX = (K > M) ? K : M;
   localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
   localparam logic [P_FLAT_W-1:0] P_EXT = P_FLAT_W'(P_MATRIX);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [M-1:0]      parity_acc_q, parity_acc_d;
   logic              out_valid_q, out_valid_d;
   logic              out_bit_q, out_bit_d;
   logic              out_sop_q, out_sop_d;
   logic              out_eop_q, out_eop_d;
   logic [WIDTH-1:0]  cw_count_q, cw_count_d;

   logic              slot_free;
   logic              in_ready_c;
   logic [PAR_ROW_W-1:0] row_full;
   logic [M-1:0]      row_sel;
   logic              par_bit;

   always_comb begin
      row_full = par_row(P_EXT, 32'(idx_q), M);
      row_sel  = row_full[M-1:0];
      par_bit  = 1'b0;
      for (int j = 0; j < M; j++) begin
         if (idx_q == IDX_W'(j)) par_bit = parity_acc_q[j];
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      parity_acc_d = parity_acc_q;
      out_valid_d  = out_valid_q;
      out_bit_d    = out_bit_q;
      out_sop_d    = out_sop_q;
      out_eop_d    = out_eop_q;
      cw_count_d   = cw_count_q;
      in_ready_c   = 1'b0;

      // Output register can take a new bit when empty or being drained now.
      slot_free = !out_valid_q || bus.out_ready;

      if (out_valid_q && bus.out_ready && out_eop_q) begin
         cw_count_d = cw_count_q + WIDTH'(1);
      end

      case (state_q)
         S_MSG: begin
            in_ready_c = slot_free;
            if (bus.in_valid && slot_free) begin
               out_bit_d    = bus.in_bit;
               out_valid_d  = 1'b1;
               out_sop_d    = (idx_q == '0);
               out_eop_d    = 1'b0;
               parity_acc_d = parity_acc_q ^ (bus.in_bit ? row_sel : '0);
               if (idx_q == IDX_W'(K - 1)) begin
                  idx_d   = '0;
                  state_d = S_PAR;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (slot_free) begin
               out_valid_d = 1'b0;
            end
         end
         S_PAR: begin
            if (slot_free) begin
               out_bit_d   = par_bit;
               out_valid_d = 1'b1;
               out_sop_d   = 1'b0;
               out_eop_d   = (idx_q == IDX_W'(M - 1));
               if (idx_q == IDX_W'(M - 1)) begin
                  idx_d        = '0;
                  parity_acc_d = '0;
                  state_d      = S_MSG;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = S_MSG;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_MSG;
         idx_q        <= '0;
         parity_acc_q <= '0;
         out_valid_q  <= 1'b0;
         out_bit_q    <= 1'b0;
         out_sop_q    <= 1'b0;
         out_eop_q    <= 1'b0;
         cw_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         parity_acc_q <= parity_acc_d;
         out_valid_q  <= out_valid_d;
         out_bit_q    <= out_bit_d;
         out_sop_q    <= out_sop_d;
         out_eop_q    <= out_eop_d;
         cw_count_q   <= cw_count_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_bit   = out_bit_q;
   assign bus.out_sop   = out_sop_q;
   assign bus.out_eop   = out_eop_q;
   assign bus.cw_count  = cw_count_q;

endmodule
